// File: rtl/icache_nway_plru.sv
// N-way instruction cache with critical-word-first fill: a hit answers next cycle, a miss takes 2 + NUM_BLOCKS transfer cycles.
// Fill is held off by mem_req_ready; proc_valid is held by the core until the proc_ready pulse.
module icache_nway_plru #(
  parameter int CACHE_SIZE     = 4096,
  parameter int NUM_WAYS       = 4,
  parameter int NUM_BLOCKS     = 4,
  parameter int REPLACE_POLICY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        proc_valid,
  input  logic [31:0] proc_addr,
  output logic        proc_ready,
  output logic [31:0] proc_rdata,
  input  logic        flush,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic [31:0] mem_req_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int NUM_SETS = CACHE_SIZE / (4 * NUM_BLOCKS * NUM_WAYS);
  localparam int OB  = $clog2(NUM_BLOCKS);
  localparam int LW  = $clog2(NUM_WAYS);
  localparam int IB  = $clog2(NUM_SETS);
  localparam int IBW = (IB > 0) ? IB : 1;
  localparam int TW  = 30 - OB - IB;
  localparam int NT  = NUM_WAYS - 1;

  typedef enum logic [1:0] {IDLE, FILL, RESP, FLUSH} state_t;
  state_t state;

  logic [31:0]         data_arr [NUM_WAYS][NUM_SETS][NUM_BLOCKS];
  logic [TW-1:0]       tag_arr  [NUM_WAYS][NUM_SETS];
  logic [NUM_WAYS-1:0] valid    [NUM_SETS];
  logic [NT-1:0]       plru     [NUM_SETS];
  logic [LW-1:0]       rr_ptr   [NUM_SETS];

  logic [TW-1:0]  lat_tag, cur_tag;
  logic [IBW-1:0] lat_set, cur_set;
  logic [OB-1:0]  lat_off, cur_off, wcnt, mem_word;
  logic [LW-1:0]  vway, hit_way, inv_way, victim;
  logic           evict_valid, flush_pend, hit, inv_found;
  logic           start, hit_acc, miss_acc, xfer, last;
  logic           unused_addr_bits;

  assign cur_tag  = proc_addr[31:32-TW];
  assign cur_off  = proc_addr[OB+1:2];
  assign cur_set  = (IB > 0) ? proc_addr[OB+2 +: IBW] : '0;
  assign mem_word = mem_req_addr[OB+1:2];
  assign unused_addr_bits = ^proc_addr[1:0];

  // Tree walk: a 0 bit at a node steers toward the lower half of the ways.
  function automatic logic [LW-1:0] plru_victim(input logic [NT-1:0] bits);
    logic [LW-1:0] node, way;
    logic b;
    node = '0;
    way  = '0;
    for (int l = 0; l < LW; l++) begin
      b    = 1'(bits >> node);
      way  = (way << 1) | LW'(b);
      node = (node << 1) + LW'(1) + LW'(b);
    end
    return way;
  endfunction

  function automatic logic [NT-1:0] plru_touch(input logic [NT-1:0] bits, input logic [LW-1:0] way);
    logic [LW-1:0] node, w;
    logic [NT-1:0] t, mask;
    logic b;
    t    = bits;
    node = '0;
    w    = way;
    for (int l = 0; l < LW; l++) begin
      b    = w[LW-1];
      mask = NT'(1) << node;
      t    = b ? (t & ~mask) : (t | mask);
      node = (node << 1) + LW'(1) + LW'(b);
      w    = w << 1;
    end
    return t;
  endfunction

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[cur_set][w] && tag_arr[w][cur_set] == cur_tag) begin
        hit     = 1'b1;
        hit_way = LW'(w);
      end
      if (!valid[cur_set][w]) begin
        inv_found = 1'b1;
        inv_way   = LW'(w);
      end
    end
  end

  assign victim   = inv_found ? inv_way :
                    (REPLACE_POLICY == 1) ? plru_victim(plru[cur_set]) : rr_ptr[cur_set];
  // A request in the cycle of a proc_ready pulse is the one just answered.
  assign start    = (state == IDLE) && proc_valid && !proc_ready && !flush && !flush_pend;
  assign hit_acc  = start && hit;
  assign miss_acc = start && !hit;
  assign xfer     = (state == FILL) && mem_req_valid && mem_req_ready;
  assign last     = xfer && (wcnt == OB'(NUM_BLOCKS - 1));

  always_ff @(posedge clk) begin
    if (miss_acc) begin
      lat_tag      <= cur_tag;
      lat_set      <= cur_set;
      lat_off      <= cur_off;
      vway         <= victim;
      evict_valid  <= !inv_found;
      mem_req_addr <= {proc_addr[31:2], 2'b00};
    end
    if (xfer) begin
      data_arr[vway][lat_set][mem_word] <= mem_req_rdata;
      mem_req_addr <= {mem_req_addr[31:OB+2], mem_word + OB'(1), 2'b00};
    end
    if (last) tag_arr[vway][lat_set] <= lat_tag;
    if (hit_acc) proc_rdata <= data_arr[hit_way][cur_set][cur_off];
    else if (state == RESP) proc_rdata <= data_arr[vway][lat_set][lat_off];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      proc_ready    <= 1'b0;
      mem_req_valid <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
      flush_pend    <= 1'b0;
      wcnt          <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s]  <= '0;
        plru[s]   <= '0;
        rr_ptr[s] <= '0;
      end
    end else begin
      proc_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (flush || flush_pend) begin
            state <= FLUSH;
          end else if (hit_acc) begin
            proc_ready <= 1'b1;
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            if (REPLACE_POLICY == 1) plru[cur_set] <= plru_touch(plru[cur_set], hit_way);
          end else if (miss_acc) begin
            state         <= FILL;
            mem_req_valid <= 1'b1;
            wcnt          <= '0;
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
          end
        end
        FILL: begin
          if (flush) flush_pend <= 1'b1;
          if (xfer) wcnt <= wcnt + OB'(1);
          if (last) begin
            mem_req_valid         <= 1'b0;
            valid[lat_set][vway]  <= 1'b1;
            state                 <= RESP;
            if (REPLACE_POLICY == 1) plru[lat_set] <= plru_touch(plru[lat_set], vway);
            else if (evict_valid) rr_ptr[lat_set] <= rr_ptr[lat_set] + LW'(1);
          end
        end
        RESP: begin
          if (flush) flush_pend <= 1'b1;
          proc_ready <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          flush_pend <= 1'b0;
          hit_count  <= '0;
          miss_count <= '0;
          state      <= IDLE;
          for (int s = 0; s < NUM_SETS; s++) begin
            valid[s]  <= '0;
            plru[s]   <= '0;
            rr_ptr[s] <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_icache_nway_plru.sv
// Bench for icache_nway_plru (256 B, 2 ways, 4 words/line, PLRU) against an LRU line model.
module tb_icache_nway_plru;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        proc_valid = 1'b0;
  logic [31:0] proc_addr = '0;
  logic        proc_ready;
  logic [31:0] proc_rdata;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_rdata = '0;
  logic [31:0] hit_count, miss_count;

  icache_nway_plru #(.CACHE_SIZE(256), .NUM_WAYS(2), .NUM_BLOCKS(4), .REPLACE_POLICY(1)) dut (
    .clk(clk), .resetn(resetn), .proc_valid(proc_valid), .proc_addr(proc_addr),
    .proc_ready(proc_ready), .proc_rdata(proc_rdata), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_req_rdata(mem_req_rdata), .hit_count(hit_count), .miss_count(miss_count));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cycles = 0;
  int stall_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] xlog[$];

  // Reference: 8 sets x 2 ways, line = 16 bytes, true LRU (equals tree PLRU for 2 ways).
  logic [31:0] rtag [8][2];
  bit          rval [8][2];
  int          rmru [8];
  int          rhits, rmiss;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h1357_9BDF;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 8; s++) begin
      rval[s][0] = 0;
      rval[s][1] = 0;
      rmru[s] = 0;
    end
    rhits = 0;
    rmiss = 0;
  endfunction

  // Memory: ready after stall_cycles idle cycles per word; logs each word that will transfer.
  always @(negedge clk) begin
    if (!resetn || !mem_req_valid) begin
      mem_req_ready = 1'b0;
      stall_cnt = 0;
    end else if (stall_cnt >= stall_cycles) begin
      mem_req_ready = 1'b1;
      mem_req_rdata = memfn(mem_req_addr);
      xlog.push_back(mem_req_addr);
      stall_cnt = 0;
    end else begin
      mem_req_ready = 1'b0;
      stall_cnt++;
      if (xlog.size() < exp_q.size()) chk("addr_stable", mem_req_addr, exp_q[xlog.size()]);
    end
  end

  task automatic fetch(input logic [31:0] a, input int stall, input bit flush_mid);
    int s, off, way, cyc;
    bit hit, done, saw_mv;
    logic [31:0] tg;
    s = int'((a >> 4) & 32'd7);
    off = int'((a >> 2) & 32'd3);
    tg = a >> 7;
    hit = 0;
    way = 0;
    for (int w = 0; w < 2; w++)
      if (rval[s][w] && rtag[s][w] == tg) begin
        hit = 1;
        way = w;
      end
    exp_q.delete();
    xlog.delete();
    if (!hit) begin
      way = !rval[s][0] ? 0 : (!rval[s][1] ? 1 : 1 - rmru[s]);
      for (int i = 0; i < 4; i++)
        exp_q.push_back({a[31:4], 4'b0} | 32'(((off + i) % 4) << 2));
    end
    stall_cycles = stall;
    @(negedge clk);
    proc_valid = 1'b1;
    proc_addr = a;
    cyc = 0;
    done = 0;
    saw_mv = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (mem_req_valid) saw_mv = 1;
      flush = flush_mid && cyc == 3;
      if (proc_ready) done = 1;
    end
    proc_valid = 1'b0;
    flush = 1'b0;
    chk("ready_seen", 32'(done), 32'd1);
    if (hit) rhits++;
    else begin
      rmiss++;
      rval[s][way] = 1;
      rtag[s][way] = tg;
    end
    rmru[s] = way;
    chk("rdata", proc_rdata, memfn({a[31:2], 2'b00}));
    chk("latency", cyc, hit ? 32'd1 : 32'(2 + 4 * (stall + 1)));
    chk("mreq_seen", 32'(saw_mv), 32'(!hit));
    chk("xfer_count", xlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk("xfer_addr", (i < xlog.size()) ? xlog[i] : 32'hDEAD_BEEF, exp_q[i]);
    if (!flush_mid) begin
      chk("hit_count", hit_count, rhits);
      chk("miss_count", miss_count, rmiss);
    end else begin
      repeat (3) @(negedge clk);
      model_clear();
      chk("hit_after_flush", hit_count, 32'd0);
      chk("miss_after_flush", miss_count, 32'd0);
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    model_clear();
    chk("flush_hits", hit_count, 32'd0);
    chk("flush_misses", miss_count, 32'd0);
  endtask

  task automatic reset_mid_fill(input logic [31:0] a);
    int cyc;
    exp_q.delete();
    xlog.delete();
    stall_cycles = 0;
    @(negedge clk);
    proc_valid = 1'b1;
    proc_addr = a;
    cyc = 0;
    while (xlog.size() < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_two_words", xlog.size(), 32'd2);
    @(posedge clk);
    #1;
    chk("rst_pre_mreq", 32'(mem_req_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_async_mreq", 32'(mem_req_valid), 32'd0);
    chk("rst_async_miss", miss_count, 32'd0);
    proc_valid = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [31:0] a;
    model_clear();
    #2;
    chk("reset_ready", 32'(proc_ready), 32'd0);
    chk("reset_mreq", 32'(mem_req_valid), 32'd0);
    chk("reset_hits", hit_count, 32'd0);
    chk("reset_misses", miss_count, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    fetch(32'h0000_0108, 0, 0);   // cold miss, critical word first
    fetch(32'h0000_0104, 0, 0);   // hit in the freshly filled line

    do_flush();
    fetch(32'h0000_0000, 0, 0);   // A
    fetch(32'h0000_0080, 0, 0);   // B
    fetch(32'h0000_0000, 0, 0);   // hit A
    fetch(32'h0000_0100, 0, 0);   // C evicts B
    fetch(32'h0000_0000, 0, 0);   // A still present
    fetch(32'h0000_0080, 0, 0);   // B gone

    fetch(32'h0000_0240, 5, 0);   // stalled fill
    fetch(32'h0000_024C, 0, 0);
    fetch(32'h0000_0244, 0, 0);

    fetch(32'h0000_0300, 0, 1);   // flush mid-fill
    fetch(32'h0000_0300, 0, 0);

    reset_mid_fill(32'h0000_1354);
    fetch(32'h0000_1354, 0, 0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(15) == 0) do_flush();
      a = (32'($urandom_range(3)) << 7) | (32'($urandom_range(1)) << 4) | (32'($urandom_range(3)) << 2);
      fetch(a, $urandom_range(2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
